// File: rtl/wb_pkg.sv
// Shared types for the write-back writer: default widths and the queued entry format.
// Build option WB_BYPASS_EN (see wb_writer) adds forwarding of queued values to ID.
package wb_pkg;

  localparam int WB_ADDR_W = 5;
  localparam int WB_DATA_W = 32;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] rd;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_queue.sv
// Circular FIFO of pending register writes; caller never pushes when full or pops when empty.
// With WB_BYPASS_EN the storage and read pointer are exported for the forwarding compare.
module wb_queue
  import wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  wb_entry_t                push_entry,
  input  logic                     pop,
  output wb_entry_t                head,
  output logic [$clog2(DEPTH):0]   count
`ifdef WB_BYPASS_EN
  ,
  output wb_entry_t                entries [DEPTH],
  output logic [$clog2(DEPTH)-1:0] oldest
`endif
);

  localparam int PTR_W = $clog2(DEPTH);

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  // DEPTH is a power of two, so pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

  assign head = mem[rd_ptr];

`ifdef WB_BYPASS_EN
  assign entries = mem;
  assign oldest  = rd_ptr;
`endif

endmodule

// File: rtl/wb_writer.sv
// Write-back driver: filters retiring results, queues them, and drains one register write per cycle.
// Define WB_BYPASS_EN to add ReadRegister1/2 forwarding from queued and in-flight writes.
module wb_writer
  import wb_pkg::*;
#(
  parameter int ADDR_W = WB_ADDR_W,
  parameter int DATA_W = WB_DATA_W,
  parameter int DEPTH  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   InValid,
  output logic                   InReady,
  input  logic                   InRegWrite,
  input  logic [ADDR_W-1:0]      InRd,
  input  logic [DATA_W-1:0]      InData,
  input  logic                   WbStall,
  output logic                   RegWrite,
  output logic [ADDR_W-1:0]      WriteRegister,
  output logic [DATA_W-1:0]      WriteData,
  output logic [$clog2(DEPTH):0] QueueCount
`ifdef WB_BYPASS_EN
  ,
  input  logic [ADDR_W-1:0]      ReadRegister1,
  input  logic [ADDR_W-1:0]      ReadRegister2,
  output logic                   Fwd1Hit,
  output logic                   Fwd2Hit,
  output logic [DATA_W-1:0]      Fwd1Data,
  output logic [DATA_W-1:0]      Fwd2Data
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic      accept;
  logic      push;
  logic      pop;
  wb_entry_t push_entry;
  wb_entry_t head;

`ifdef WB_BYPASS_EN
  wb_entry_t        entries [DEPTH];
  logic [PTR_W-1:0] oldest;
`endif

  // Ready depends on occupancy alone, so a full queue never takes a push alongside a pop.
  assign InReady = (QueueCount < CNT_W'(DEPTH));
  assign accept  = InValid && InReady;
  // Non-writing results and x0 targets complete the handshake but are never queued.
  assign push    = accept && InRegWrite && (InRd != '0);
  assign pop     = !WbStall && (QueueCount != '0);

  assign push_entry.rd   = InRd;
  assign push_entry.data = InData;

  wb_queue #(
    .DEPTH(DEPTH)
  ) u_queue (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .count      (QueueCount)
`ifdef WB_BYPASS_EN
    ,
    .entries    (entries),
    .oldest     (oldest)
`endif
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      RegWrite      <= 1'b0;
      WriteRegister <= '0;
      WriteData     <= '0;
    end else if (pop) begin
      RegWrite      <= 1'b1;
      WriteRegister <= head.rd;
      WriteData     <= head.data;
    end else begin
      RegWrite      <= 1'b0;
    end
  end

`ifdef WB_BYPASS_EN
  // Scan oldest to youngest so the youngest match overrides; output register is the fallback.
  function automatic logic [DATA_W:0] lookup(input logic [ADDR_W-1:0] rs);
    logic [DATA_W:0]  res;
    logic [PTR_W-1:0] idx;
    res = '0;
    if (rs != '0) begin
      if (RegWrite && (WriteRegister == rs)) res = {1'b1, WriteData};
      for (int k = 0; k < DEPTH; k++) begin
        idx = oldest + PTR_W'(k);
        if ((CNT_W'(k) < QueueCount) && (entries[idx].rd == rs))
          res = {1'b1, entries[idx].data};
      end
    end
    return res;
  endfunction

  always_comb begin
    {Fwd1Hit, Fwd1Data} = lookup(ReadRegister1);
    {Fwd2Hit, Fwd2Data} = lookup(ReadRegister2);
  end
`endif

endmodule

// File: tb/tb_wb_writer.sv
// Directed self-checking bench for wb_writer; bypass scenario compiles in with WB_BYPASS_EN.
module tb_wb_writer;

  logic        clk;
  logic        rst;
  logic        InValid;
  logic        InReady;
  logic        InRegWrite;
  logic [4:0]  InRd;
  logic [31:0] InData;
  logic        WbStall;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData;
  logic [1:0]  QueueCount;
`ifdef WB_BYPASS_EN
  logic [4:0]  ReadRegister1;
  logic [4:0]  ReadRegister2;
  logic        Fwd1Hit;
  logic        Fwd2Hit;
  logic [31:0] Fwd1Data;
  logic [31:0] Fwd2Data;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  wb_writer #(
    .ADDR_W(5),
    .DATA_W(32),
    .DEPTH (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .InValid       (InValid),
    .InReady       (InReady),
    .InRegWrite    (InRegWrite),
    .InRd          (InRd),
    .InData        (InData),
    .WbStall       (WbStall),
    .RegWrite      (RegWrite),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .QueueCount    (QueueCount)
`ifdef WB_BYPASS_EN
    ,
    .ReadRegister1 (ReadRegister1),
    .ReadRegister2 (ReadRegister2),
    .Fwd1Hit       (Fwd1Hit),
    .Fwd2Hit       (Fwd2Hit),
    .Fwd1Data      (Fwd1Data),
    .Fwd2Data      (Fwd2Data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic we, input logic [4:0] rd, input logic [31:0] d);
    InValid    = v;
    InRegWrite = we;
    InRd       = rd;
    InData     = d;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 5'd0, 32'd0);
    WbStall = 1'b0;
    step();
    step();
    rst = 1'b0;
    #1;
    n_checks++;
    if (QueueCount !== 2'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", QueueCount); end
    n_checks++;
    if (InReady !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", InReady); end
    n_checks++;
    if ({RegWrite, WriteRegister, WriteData} !== 38'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got we=%b rd=%0d data=%h want all zero", RegWrite, WriteRegister, WriteData);
    end
  endtask

  task automatic test_single_write();
    drive(1'b1, 1'b1, 5'd7, 32'hA5A5A5A5);
    step();
    drive(1'b0, 1'b0, 5'd0, 32'd0);
    n_checks++;
    if (QueueCount !== 2'd1 || RegWrite !== 1'b0) begin
      n_fail++;
      $display("FAIL single_enqueue: got count=%0d we=%b want count=1 we=0", QueueCount, RegWrite);
    end
    step();
    n_checks++;
    if (RegWrite !== 1'b1 || WriteRegister !== 5'd7 || WriteData !== 32'hA5A5A5A5) begin
      n_fail++;
      $display("FAIL single_write: got we=%b rd=%0d data=%h want we=1 rd=7 data=a5a5a5a5", RegWrite, WriteRegister, WriteData);
    end
    step();
    n_checks++;
    if (RegWrite !== 1'b0 || WriteRegister !== 5'd7 || QueueCount !== 2'd0) begin
      n_fail++;
      $display("FAIL single_done: got we=%b rd=%0d count=%0d want we=0 rd=7 count=0", RegWrite, WriteRegister, QueueCount);
    end
  endtask

  task automatic test_drop();
    #1;
    n_checks++;
    if (InReady !== 1'b1) begin n_fail++; $display("FAIL drop_ready: got %b want 1", InReady); end
    drive(1'b1, 1'b1, 5'd0, 32'hFFFFFFFF);
    step();
    drive(1'b1, 1'b0, 5'd9, 32'h12345678);
    n_checks++;
    if (QueueCount !== 2'd0) begin n_fail++; $display("FAIL drop_x0_count: got %0d want 0", QueueCount); end
    step();
    drive(1'b0, 1'b0, 5'd0, 32'd0);
    n_checks++;
    if (QueueCount !== 2'd0 || RegWrite !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_nowrite: got count=%0d we=%b want count=0 we=0", QueueCount, RegWrite);
    end
    step();
    n_checks++;
    if (RegWrite !== 1'b0 || WriteData !== 32'hA5A5A5A5) begin
      n_fail++;
      $display("FAIL drop_hold: got we=%b data=%h want we=0 data=a5a5a5a5", RegWrite, WriteData);
    end
  endtask

  task automatic test_stall_full();
    WbStall = 1'b1;
    drive(1'b1, 1'b1, 5'd3, 32'd1);
    step();
    drive(1'b1, 1'b1, 5'd5, 32'd2);
    step();
    drive(1'b1, 1'b1, 5'd9, 32'd99);
    n_checks++;
    if (QueueCount !== 2'd2 || InReady !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_full: got count=%0d ready=%b want count=2 ready=0", QueueCount, InReady);
    end
    step();
    n_checks++;
    if (QueueCount !== 2'd2 || RegWrite !== 1'b0 || InReady !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_hold: got count=%0d we=%b ready=%b want count=2 we=0 ready=0", QueueCount, RegWrite, InReady);
    end
    drive(1'b0, 1'b0, 5'd0, 32'd0);
    WbStall = 1'b0;
    step();
    n_checks++;
    if (RegWrite !== 1'b1 || WriteRegister !== 5'd3 || WriteData !== 32'd1 || InReady !== 1'b1 || QueueCount !== 2'd1) begin
      n_fail++;
      $display("FAIL stall_drain1: got we=%b rd=%0d data=%0d ready=%b count=%0d want 1/3/1/1/1",
               RegWrite, WriteRegister, WriteData, InReady, QueueCount);
    end
    step();
    n_checks++;
    if (RegWrite !== 1'b1 || WriteRegister !== 5'd5 || WriteData !== 32'd2 || QueueCount !== 2'd0) begin
      n_fail++;
      $display("FAIL stall_drain2: got we=%b rd=%0d data=%0d count=%0d want 1/5/2/0", RegWrite, WriteRegister, WriteData, QueueCount);
    end
    step();
    n_checks++;
    if (RegWrite !== 1'b0) begin n_fail++; $display("FAIL stall_idle: got we=%b want 0", RegWrite); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, 5'(i + 1), 32'h100 + 32'(i));
      step();
      n_checks++;
      if (QueueCount > 2'd1) begin
        n_fail++;
        $display("FAIL b2b_count[%0d]: got %0d want <=1", i, QueueCount);
      end
      if (i > 0) begin
        n_checks++;
        if (RegWrite !== 1'b1 || WriteRegister !== 5'(i) || WriteData !== 32'h100 + 32'(i - 1)) begin
          n_fail++;
          $display("FAIL b2b_write[%0d]: got we=%b rd=%0d data=%h want we=1 rd=%0d data=%h",
                   i, RegWrite, WriteRegister, WriteData, i, 32'h100 + 32'(i - 1));
        end
      end
    end
    drive(1'b0, 1'b0, 5'd0, 32'd0);
    step();
    n_checks++;
    if (RegWrite !== 1'b1 || WriteRegister !== 5'd8 || WriteData !== 32'h107) begin
      n_fail++;
      $display("FAIL b2b_last: got we=%b rd=%0d data=%h want we=1 rd=8 data=107", RegWrite, WriteRegister, WriteData);
    end
    step();
    n_checks++;
    if (RegWrite !== 1'b0 || QueueCount !== 2'd0) begin
      n_fail++;
      $display("FAIL b2b_end: got we=%b count=%0d want we=0 count=0", RegWrite, QueueCount);
    end
  endtask

  task automatic test_same_reg();
    WbStall = 1'b1;
    drive(1'b1, 1'b1, 5'd4, 32'h11);
    step();
    drive(1'b1, 1'b1, 5'd4, 32'h22);
    step();
    drive(1'b0, 1'b0, 5'd0, 32'd0);
    WbStall = 1'b0;
    step();
    n_checks++;
    if (RegWrite !== 1'b1 || WriteRegister !== 5'd4 || WriteData !== 32'h11) begin
      n_fail++;
      $display("FAIL same_reg_first: got we=%b rd=%0d data=%h want we=1 rd=4 data=11", RegWrite, WriteRegister, WriteData);
    end
    step();
    n_checks++;
    if (RegWrite !== 1'b1 || WriteRegister !== 5'd4 || WriteData !== 32'h22) begin
      n_fail++;
      $display("FAIL same_reg_second: got we=%b rd=%0d data=%h want we=1 rd=4 data=22", RegWrite, WriteRegister, WriteData);
    end
    step();
  endtask

`ifdef WB_BYPASS_EN
  task automatic test_bypass();
    WbStall = 1'b1;
    drive(1'b1, 1'b1, 5'd7, 32'd10);
    step();
    drive(1'b1, 1'b1, 5'd7, 32'd20);
    step();
    drive(1'b0, 1'b0, 5'd0, 32'd0);
    ReadRegister1 = 5'd7;
    ReadRegister2 = 5'd0;
    #1;
    n_checks++;
    if (Fwd1Hit !== 1'b1 || Fwd1Data !== 32'd20) begin
      n_fail++;
      $display("FAIL bypass_youngest: got hit=%b data=%0d want hit=1 data=20", Fwd1Hit, Fwd1Data);
    end
    n_checks++;
    if (Fwd2Hit !== 1'b0 || Fwd2Data !== 32'd0) begin
      n_fail++;
      $display("FAIL bypass_x0: got hit=%b data=%0d want hit=0 data=0", Fwd2Hit, Fwd2Data);
    end
    WbStall = 1'b0;
    step();
    step();
    n_checks++;
    if (Fwd1Hit !== 1'b1 || Fwd1Data !== 32'd20 || QueueCount !== 2'd0) begin
      n_fail++;
      $display("FAIL bypass_outreg: got hit=%b data=%0d count=%0d want hit=1 data=20 count=0", Fwd1Hit, Fwd1Data, QueueCount);
    end
    step();
    n_checks++;
    if (Fwd1Hit !== 1'b0 || Fwd1Data !== 32'd0) begin
      n_fail++;
      $display("FAIL bypass_clear: got hit=%b data=%0d want hit=0 data=0", Fwd1Hit, Fwd1Data);
    end
    ReadRegister1 = 5'd0;
  endtask
`endif

  task automatic test_reset_mid();
    WbStall = 1'b1;
    drive(1'b1, 1'b1, 5'd12, 32'hDEAD);
    step();
    drive(1'b1, 1'b1, 5'd13, 32'hBEEF);
    step();
    drive(1'b0, 1'b0, 5'd0, 32'd0);
    n_checks++;
    if (QueueCount !== 2'd2) begin n_fail++; $display("FAIL rstmid_fill: got %0d want 2", QueueCount); end
    rst     = 1'b1;
    WbStall = 1'b0;
    step();
    rst = 1'b0;
    n_checks++;
    if (QueueCount !== 2'd0 || RegWrite !== 1'b0 || WriteRegister !== 5'd0) begin
      n_fail++;
      $display("FAIL rstmid_clear: got count=%0d we=%b rd=%0d want 0/0/0", QueueCount, RegWrite, WriteRegister);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (RegWrite !== 1'b0) begin
        n_fail++;
        $display("FAIL rstmid_nowrite[%0d]: got we=%b rd=%0d want we=0", i, RegWrite, WriteRegister);
      end
    end
  endtask

  initial begin
`ifdef WB_BYPASS_EN
    ReadRegister1 = 5'd0;
    ReadRegister2 = 5'd0;
`endif
    test_reset();
    test_single_write();
    test_drop();
    test_stall_full();
    test_back_to_back();
    test_same_reg();
`ifdef WB_BYPASS_EN
    test_bypass();
`endif
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
